// File: rtl/gene_scan_pkg.sv
// rtl/gene_scan_pkg.sv - shared types, sizes and element compare for the gene scan engine (GENE_SCAN_WILDCARD_EN selects wildcard compare)
package gene_scan_pkg;

  localparam int ELEMENT_SIZE     = 4;
  localparam int CODON_MAX_LENGTH = 5;
  localparam int ELEMENT_COUNT    = 32;
  localparam int SEGMENT_SIZE     = ELEMENT_COUNT + CODON_MAX_LENGTH - 1;
  localparam int MAX_CODONS       = 6;
  localparam int MAX_COUNT        = 16;
  localparam int COUNT_W          = $clog2(MAX_COUNT + 1);
  localparam int IDX_W            = $clog2(MAX_CODONS);
  localparam int LEN_W            = $clog2(CODON_MAX_LENGTH + 1);
  localparam int POS_W            = $clog2(SEGMENT_SIZE + 1);

  typedef logic [ELEMENT_SIZE-1:0] element_t;

  // All-ones element code ('N'); only special when wildcard compare is built in
  localparam element_t WILDCARD = '1;

  typedef struct packed {
    logic [LEN_W-1:0]                  len;
    element_t [CODON_MAX_LENGTH-1:0]   elems;
  } codon_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } scan_state_e;

  // One codon element against one stream element
  function automatic logic elem_match(input element_t pat, input element_t el);
`ifdef GENE_SCAN_WILDCARD_EN
    return (pat == WILDCARD) || (pat == el);
`else
    return (pat == el);
`endif
  endfunction

endpackage

// File: rtl/gene_scan_engine_codon_matcher.sv
// rtl/gene_scan_engine_codon_matcher.sv - compare the registered window against one codon and keep its saturating count
module codon_matcher
  import gene_scan_pkg::*;
(
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clear_i,
  input  logic                                 win_vld_i,
  input  logic [POS_W-1:0]                     fill_i,
  input  element_t [CODON_MAX_LENGTH-1:0]      window_i,
  input  codon_t                               codon_i,
  output logic [COUNT_W-1:0]                   count_o
);

  logic                hit;
  logic [COUNT_W-1:0]  count_q;

  // window_i[0] is the newest element, so codon elem k lines up with window_i[len-1-k];
  // fill_i is the number of elements accepted so far, giving start = fill_i - len
  always_comb begin : p_hit
    int   len_v;
    int   start_v;
    int   j;
    logic all_v;
    hit     = 1'b0;
    len_v   = int'(codon_i.len);
    start_v = int'(fill_i) - len_v;
    all_v   = 1'b1;
    for (int k = 0; k < CODON_MAX_LENGTH; k++) begin
      j = len_v - 1 - k;
      if (k < len_v && j >= 0 && j < CODON_MAX_LENGTH) begin
        if (!elem_match(codon_i.elems[k], window_i[j])) all_v = 1'b0;
      end
    end
    if (win_vld_i && len_v >= 1 && len_v <= CODON_MAX_LENGTH &&
        start_v >= 0 && start_v < ELEMENT_COUNT) begin
      hit = all_v;
    end
  end

  // Saturating occurrence counter, cleared when a scan starts
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (hit && count_q != COUNT_W'(MAX_COUNT)) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/gene_scan_engine.sv
// rtl/gene_scan_engine.sv - codon occurrence counter for one gene segment: FSM, window, codon table (GENE_SCAN_WILDCARD_EN enables 'N' wildcard)
module gene_scan_engine
  import gene_scan_pkg::*;
(
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      start_i,
  output logic                                      busy_o,
  output logic                                      done_o,
  input  logic                                      elem_valid_i,
  output logic                                      elem_ready_o,
  input  logic [ELEMENT_SIZE-1:0]                   elem_data_i,
  input  logic                                      codon_we_i,
  input  logic [IDX_W-1:0]                          codon_idx_i,
  input  logic [LEN_W-1:0]                          codon_len_i,
  input  logic [CODON_MAX_LENGTH*ELEMENT_SIZE-1:0]  codon_data_i,
  output logic [MAX_CODONS*COUNT_W-1:0]             counts_o
);

  scan_state_e                       state_q;
  logic                              busy_q;
  logic                              done_q;
  logic                              ready_q;
  logic                              win_vld_q;
  logic [POS_W-1:0]                  pos_q;
  element_t [CODON_MAX_LENGTH-1:0]   win_q;
  codon_t [MAX_CODONS-1:0]           table_q;

  logic xfer;
  logic start_acc;

  assign xfer      = elem_valid_i & ready_q;
  assign start_acc = start_i & (state_q == S_IDLE);

  // Scan sequencing plus the element window and fill count it owns
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      win_vld_q <= 1'b0;
      pos_q     <= '0;
      win_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      win_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_SCAN;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
            pos_q   <= '0;
            win_q   <= '0;
          end
        end
        S_SCAN: begin
          if (xfer) begin
            win_q     <= {win_q[CODON_MAX_LENGTH-2:0], element_t'(elem_data_i)};
            pos_q     <= pos_q + POS_W'(1);
            win_vld_q <= 1'b1;
            if (pos_q == POS_W'(SEGMENT_SIZE - 1)) begin
              state_q <= S_DRAIN;
              ready_q <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // last element's compare lands in the counters at the end of this cycle
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Codon table, writable only while idle; lengths reset to 0 so every entry starts disabled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      table_q <= '0;
    end else if (codon_we_i && state_q == S_IDLE && codon_idx_i < IDX_W'(MAX_CODONS)) begin
      table_q[codon_idx_i] <= {codon_len_i, codon_data_i};
    end
  end

  for (genvar i = 0; i < MAX_CODONS; i++) begin : g_match
    logic [COUNT_W-1:0] count;
    codon_matcher u_match (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (start_acc),
      .win_vld_i (win_vld_q),
      .fill_i    (pos_q),
      .window_i  (win_q),
      .codon_i   (table_q[i]),
      .count_o   (count)
    );
    assign counts_o[i*COUNT_W +: COUNT_W] = count;
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign elem_ready_o = ready_q;

endmodule
